// File: rtl/conv_scan_ctrl_pkg.sv
// Shared types and defaults for the conv MAC array raster-scan sequencer.
package conv_scan_ctrl_pkg;

  localparam int unsigned W_SIZE_DEF  = 12;
  localparam int unsigned ROW_GAP_DEF = 2;
  localparam int unsigned CNT_W_DEF   = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GAP   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/conv_scan_ctrl_if.sv
// Start/size request, back-pressure, MAC return and scan outputs of conv_scan_ctrl.
interface conv_scan_ctrl_if #(
  parameter int unsigned W_SIZE = conv_scan_ctrl_pkg::W_SIZE_DEF
);
  logic              q_start;
  logic [W_SIZE-1:0] q_width;
  logic [W_SIZE-1:0] q_height;
  logic              stall;
  logic              mac_vld;
  logic              ctrl_data_run;
  logic [W_SIZE-1:0] row;
  logic [W_SIZE-1:0] col;
  logic              is_first_row;
  logic              is_last_row;
  logic              is_first_col;
  logic              is_last_col;
  logic              busy;
  logic              done;

  modport master (
    output q_start, q_width, q_height, stall, mac_vld,
    input  ctrl_data_run, row, col, is_first_row, is_last_row,
           is_first_col, is_last_col, busy, done
  );

  modport slave (
    input  q_start, q_width, q_height, stall, mac_vld,
    output ctrl_data_run, row, col, is_first_row, is_last_row,
           is_first_col, is_last_col, busy, done
  );

endinterface

// File: rtl/conv_scan_ctrl.sv
// Raster-scan sequencer for the 3x3 conv MAC array: walks (row,col) over the frame with a
// refill gap before every row, then waits for all MAC outputs before pulsing done.
module conv_scan_ctrl
  import conv_scan_ctrl_pkg::*;
#(
  parameter int unsigned W_SIZE  = W_SIZE_DEF,
  parameter int unsigned ROW_GAP = ROW_GAP_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  conv_scan_ctrl_if.slave bus
);

  localparam logic [W_SIZE-1:0] ONE      = W_SIZE'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]        GAP_LAST = 8'(ROW_GAP - 1);

  state_e            state_q, state_d;
  logic [7:0]        gap_q;
  logic [W_SIZE-1:0] row_q, row_d, col_q, col_d;
  logic [W_SIZE-1:0] wid_q, wid_d, hgt_q, hgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, total_q;
  logic              first_row_q, last_row_q, first_col_q, last_col_q;
  logic              start_acc, run, busy, at_last_col, at_last_row;

  assign busy        = (state_q != IDLE);
  assign start_acc   = (state_q == IDLE) && bus.q_start;
  assign run         = (state_q == RUN) && !bus.stall;
  assign at_last_col = (col_q == wid_q - ONE);
  assign at_last_row = (row_q == hgt_q - ONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // DRAIN looks at the post-increment count so done follows the last MAC output by one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.q_start)
                 state_d = (bus.q_width == '0 || bus.q_height == '0) ? DONE : GAP;
      GAP:     if (gap_q == GAP_LAST) state_d = RUN;
      RUN:     if (!bus.stall && at_last_col) state_d = at_last_row ? DRAIN : GAP;
      DRAIN:   if (cnt_d == total_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              gap_q <= '0;
    else if (state_q != GAP) gap_q <= '0;
    else                     gap_q <= gap_q + 8'd1;
  end

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    wid_d = wid_q;
    hgt_d = hgt_q;
    if (start_acc) begin
      wid_d = bus.q_width;
      hgt_d = bus.q_height;
      row_d = '0;
      col_d = '0;
    end else if (run) begin
      if (at_last_col) begin
        col_d = '0;
        if (!at_last_row) row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
      wid_q <= '0;
      hgt_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      wid_q <= wid_d;
      hgt_q <= hgt_d;
    end
  end

  // Edge flags are registered from the next coordinates so they line up with row/col.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_row_q <= 1'b0;
      last_row_q  <= 1'b0;
      first_col_q <= 1'b0;
      last_col_q  <= 1'b0;
    end else begin
      first_row_q <= (row_d == '0);
      last_row_q  <= (row_d == hgt_d - ONE);
      first_col_q <= (col_d == '0);
      last_col_q  <= (col_d == wid_d - ONE);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_acc)
      cnt_d = '0;
    else if (busy && bus.mac_vld && (cnt_q != total_q))
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      total_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (start_acc) total_q <= CNT_W'(bus.q_width) * CNT_W'(bus.q_height);
    end
  end

  assign bus.ctrl_data_run = run;
  assign bus.row           = row_q;
  assign bus.col           = col_q;
  assign bus.is_first_row  = first_row_q;
  assign bus.is_last_row   = last_row_q;
  assign bus.is_first_col  = first_col_q;
  assign bus.is_last_col   = last_col_q;
  assign bus.busy          = busy;
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Self-checking bench for conv_scan_ctrl: frame table, hand sequences and random frames
// against a queue-based scan model.
module tb_conv_scan_ctrl;

  localparam int unsigned G = 2;

  typedef struct {
    int unsigned w, h, d, stall_len, extra;
    bit          hold_start;
    int unsigned exp_runs, exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  conv_scan_ctrl_if #(.W_SIZE(12)) bus ();

  conv_scan_ctrl #(.W_SIZE(12), .ROW_GAP(G), .CNT_W(24)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int unsigned     n_checks = 0;
  int unsigned     n_pass   = 0;
  longint unsigned cyc      = 0;

  // Scan model: pending pixels in raster order plus the idle cycles owed before the next one.
  bit          m_busy, m_done_now, m_drain;
  int unsigned m_w, m_h, m_total, m_out, m_wait;
  int unsigned q_r[$], q_c[$];
  int unsigned runs_seen;
  logic        obs_run, obs_done;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_busy = 0; m_done_now = 0; m_drain = 0;
    m_w = 0; m_h = 0; m_total = 0; m_out = 0; m_wait = 0;
    q_r.delete(); q_c.delete();
  endtask

  task automatic cycle(input bit st, input bit stl, input bit mv,
                       input int unsigned wi, input int unsigned hi);
    bit elig, exp_run;
    int unsigned r, c;
    @(posedge clk); #1;
    bus.q_start = st; bus.stall = stl; bus.mac_vld = mv;
    bus.q_width = 12'(wi); bus.q_height = 12'(hi);
    @(negedge clk);
    cyc++;
    elig    = m_busy && !m_done_now && !m_drain && q_r.size() != 0 && m_wait == 0;
    exp_run = elig && !stl;
    check("run", bus.ctrl_data_run, exp_run);
    check("busy", bus.busy, m_busy);
    check("done", bus.done, m_done_now);
    if (elig) begin
      check("row", bus.row, q_r[0]);
      check("col", bus.col, q_c[0]);
      if (exp_run) begin
        check("first_row", bus.is_first_row, q_r[0] == 0);
        check("last_row",  bus.is_last_row,  q_r[0] == m_h - 1);
        check("first_col", bus.is_first_col, q_c[0] == 0);
        check("last_col",  bus.is_last_col,  q_c[0] == m_w - 1);
      end
    end
    obs_run  = bus.ctrl_data_run;
    obs_done = bus.done;
    if (obs_run) runs_seen++;
    if (!m_busy) begin
      if (st) begin
        m_w = wi; m_h = hi; m_total = wi * hi; m_out = 0; m_busy = 1;
        q_r.delete(); q_c.delete();
        for (int unsigned rr = 0; rr < hi; rr++)
          for (int unsigned cc = 0; cc < wi; cc++) begin q_r.push_back(rr); q_c.push_back(cc); end
        if (m_total == 0) m_done_now = 1;
        else m_wait = G;
      end
    end else if (m_done_now) begin
      m_done_now = 0; m_busy = 0;
    end else begin
      if (mv && m_out < m_total) m_out++;
      if (m_drain) begin
        if (m_out == m_total) begin m_drain = 0; m_done_now = 1; end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (!stl) begin
        r = q_r.pop_front(); c = q_c.pop_front();
        if (q_r.size() == 0) m_drain = 1;
        else if (c == m_w - 1) m_wait = G;
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input bit rnd, input string tag);
    logic [63:0] hist;
    int unsigned sent, extra_left, start_cyc, done_cyc, n_done, budget, stalled, wi, hi;
    bit st, stl, mv, seen_done;
    hist = '0; sent = 0; extra_left = v.extra; n_done = 0; stalled = 0;
    seen_done = 0; done_cyc = 0; runs_seen = 0;
    budget = (v.w + G + 1) * (v.h + 1) * 2 + v.d + 64;
    cycle(1'b1, 1'b0, 1'b0, v.w, v.h);
    start_cyc = int'(cyc);
    for (int unsigned k = 0; k < budget && !seen_done; k++) begin
      st = 0; wi = v.w; hi = v.h;
      if (v.hold_start || (rnd && $urandom_range(0, 7) == 0)) begin
        st = 1; wi = $urandom_range(0, 9); hi = $urandom_range(0, 9);
      end
      stl = 0;
      if (v.stall_len > 0 && stalled < v.stall_len && !m_drain && m_wait == 0 &&
          q_r.size() != 0 && q_r[0] == 1 && q_c[0] == 1) begin
        stl = 1; stalled++;
      end
      if (rnd) stl = ($urandom_range(0, 3) == 0);
      mv = hist[v.d - 1];
      if (rnd && $urandom_range(0, 7) == 0) mv = 1;
      if (sent >= v.w * v.h && extra_left > 0) begin mv = 1; extra_left--; end
      if (mv) sent++;
      cycle(st, stl, mv, wi, hi);
      hist = {hist[62:0], obs_run};
      if (obs_done) begin seen_done = 1; done_cyc = int'(cyc); n_done++; end
    end
    if (!seen_done) begin
      n_checks++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, budget);
    end
    for (int unsigned k = 0; k < v.extra + 2; k++) begin
      mv = (extra_left > 0);
      if (mv) extra_left--;
      cycle(1'b0, 1'b0, mv, 0, 0);
      if (obs_done) n_done++;
    end
    check({tag, "_runs"}, runs_seen, v.exp_runs);
    check({tag, "_done_pulses"}, n_done, 1);
    if (!rnd && seen_done) check({tag, "_done_latency"}, done_cyc - start_cyc, v.exp_done);
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_run"}, bus.ctrl_data_run, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_row"}, bus.row, 0);
    check({tag, "_col"}, bus.col, 0);
    check({tag, "_flags"}, {bus.is_first_row, bus.is_last_row, bus.is_first_col, bus.is_last_col}, 0);
  endtask

  vec_t tbl[8];
  vec_t v;
  bit   reached;

  initial begin
    tbl[0] = '{4, 3, 4, 0, 0,  1'b0, 12, 23};  // basic 4x3 frame
    tbl[1] = '{4, 3, 4, 3, 0,  1'b0, 12, 26};  // 3-cycle stall at (1,1)
    tbl[2] = '{1, 1, 3, 0, 0,  1'b0, 1,  7};   // single pixel, all edges
    tbl[3] = '{0, 5, 4, 0, 0,  1'b1, 0,  1};   // zero width, start held while busy
    tbl[4] = '{4, 3, 4, 0, 20, 1'b0, 12, 23};  // 20 surplus mac_vld pulses
    tbl[5] = '{2, 5, 1, 0, 0,  1'b1, 10, 22};  // restart requests ignored mid-frame
    tbl[6] = '{5, 1, 2, 0, 0,  1'b0, 5,  10};  // single row
    tbl[7] = '{3, 0, 4, 0, 0,  1'b0, 0,  1};   // zero height

    rstn = 1'b0;
    bus.q_start = 0; bus.stall = 0; bus.mac_vld = 0; bus.q_width = '0; bus.q_height = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_clear("reset");
    rstn = 1'b1;

    for (int unsigned i = 0; i < 8; i++) run_frame(tbl[i], 1'b0, $sformatf("vec%0d", i));

    for (int unsigned i = 0; i < 30; i++) begin
      v.w = $urandom_range(0, 6); v.h = $urandom_range(0, 5); v.d = $urandom_range(1, 8);
      v.stall_len = 0; v.extra = 0; v.hold_start = 0;
      v.exp_runs = v.w * v.h; v.exp_done = 0;
      run_frame(v, 1'b1, $sformatf("rnd%0d", i));
    end

    // Abort a 256x256 frame in the middle of row 10, then rerun it to completion.
    reached = 0;
    cycle(1'b1, 1'b0, 1'b0, 256, 256);
    for (int unsigned k = 0; k < 4000 && !reached; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 256, 256);
      check("abort_no_done", obs_done, 0);
      if (q_r.size() != 0 && q_r[0] == 10 && q_c[0] == 50 && m_wait == 0) reached = 1;
    end
    check("abort_reached", reached, 1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    check_all_clear("abort");
    model_reset();
    repeat (2) @(negedge clk);
    check_all_clear("abort_hold");
    rstn = 1'b1;

    v = '{256, 256, 4, 0, 0, 1'b0, 65536, 66053};
    run_frame(v, 1'b0, "big");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
